// File: rtl/c1_bus_master.sv
// c1_bus_master: queued CPU-side master for the two-phase C1 cache bus.
// Ports: req_* valid/ready request queue input; rsp_* one-cycle completion
//   (data, timeout error, latency); addr_bus out, cmd_bus/data_bus tri-state
//   driven while bus_own=1.
// Build option: C1M_LATENCY_STATS_EN enables rsp_latency and max_latency.
module c1_bus_master #(
  parameter int TAG_W       = 10,
  parameter int SET_W       = 5,
  parameter int OFFSET_W    = 4,
  parameter int DATA_W      = 16,
  parameter int QDEPTH      = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int AB_W        = (TAG_W + SET_W > OFFSET_W) ?
                              TAG_W + SET_W : OFFSET_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_cmd,
  input  logic [TAG_W+SET_W+OFFSET_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0]             req_wdata,
  output logic                            rsp_valid,
  output logic [2*DATA_W-1:0]             rsp_rdata,
  output logic                            rsp_err,
  output logic [15:0]                     rsp_latency,
  output logic [AB_W-1:0]                 addr_bus,
  inout  wire  [2:0]                      cmd_bus,
  inout  wire  [DATA_W-1:0]               data_bus,
  output logic                            bus_own
);

  localparam int AW  = TAG_W + SET_W + OFFSET_W;
  localparam int PW  = $clog2(QDEPTH);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int R16 = (DATA_W < 16) ? DATA_W : 16;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_RD8  = 3'd1;
  localparam logic [2:0] C_RD16 = 3'd2;
  localparam logic [2:0] C_RD32 = 3'd3;
  localparam logic [2:0] C_WR32 = 3'd7;
  localparam logic [2:0] C_RSP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA1, S_WAIT, S_RD1, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]          fifo_cmd_q   [QDEPTH];
  logic [AW-1:0]       fifo_addr_q  [QDEPTH];
  logic [2*DATA_W-1:0] fifo_wdata_q [QDEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                full, push, pop;

  logic [2:0]          cur_cmd_q, cur_cmd_d;
  logic [AW-1:0]       cur_addr_q, cur_addr_d;
  logic [2*DATA_W-1:0] cur_wdata_q, cur_wdata_d;
  logic [2*DATA_W-1:0] rbuf_q, rbuf_d;
  logic [TW-1:0]       wcnt_q, wcnt_d;
  logic                timeout, rsp_hit, is_wr, is_rd;
  logic [DATA_W-1:0]   b0_cap;

  logic                own_q, own_d;
  logic [2:0]          cmd_o_q, cmd_o_d;
  logic [DATA_W-1:0]   data_o_q, data_o_d;
  logic [AB_W-1:0]     addr_o_q, addr_o_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [2*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // NOP requests are accepted but never stored
  assign full      = (cnt_q == (PW+1)'(QDEPTH));
  assign req_ready = !full;
  assign push      = req_valid && !full && (req_cmd != C_NOP);
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);

  assign is_wr   = cur_cmd_q[2] && (cur_cmd_q[1:0] != 2'b00);
  assign is_rd   = !cur_cmd_q[2] && (cur_cmd_q != C_NOP);
  // first WAIT cycle is bus turnaround: nothing valid on cmd_bus yet
  assign rsp_hit = (cmd_bus == C_RSP) && (wcnt_q > TW'(1));

  always_comb begin
    b0_cap = '0;
    unique case (cur_cmd_q)
      C_RD8:   b0_cap = DATA_W'(data_bus[7:0]);
      C_RD16:  b0_cap = DATA_W'(data_bus[R16-1:0]);
      C_RD32:  b0_cap = data_bus;
      default: b0_cap = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

    state_d     = state_q;
    cur_cmd_d   = cur_cmd_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    rbuf_d      = rbuf_q;
    wcnt_d      = wcnt_q;
    timeout     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_cmd_d   = fifo_cmd_q[rd_ptr_q];
          cur_addr_d  = fifo_addr_q[rd_ptr_q];
          cur_wdata_d = fifo_wdata_q[rd_ptr_q];
          state_d     = S_ADDR_HI;
        end
      end
      S_ADDR_HI: state_d = S_ADDR_LO;
      S_ADDR_LO: begin
        state_d = (cur_cmd_q == C_WR32) ? S_DATA1 : S_WAIT;
        wcnt_d  = TW'(1);
        rbuf_d  = '0;
      end
      S_DATA1: begin
        state_d = S_WAIT;
        wcnt_d  = TW'(1);
      end
      S_WAIT: begin
        if (rsp_hit) begin
          if (is_rd) rbuf_d = {{DATA_W{1'b0}}, b0_cap};
          state_d = (cur_cmd_q == C_RD32) ? S_RD1 : S_DONE;
        end else if (wcnt_q == TW'(TIMEOUT_CYC)) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      S_RD1: begin
        rbuf_d  = {data_bus, rbuf_q[DATA_W-1:0]};
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // bus and response registers are loaded from the next state
    own_d    = !(state_d == S_WAIT || state_d == S_RD1);
    cmd_o_d  = C_NOP;
    addr_o_d = '0;
    data_o_d = '0;
    unique case (state_d)
      S_ADDR_HI: begin
        cmd_o_d  = cur_cmd_d;
        addr_o_d = AB_W'(cur_addr_d[AW-1:OFFSET_W]);
      end
      S_ADDR_LO: begin
        cmd_o_d  = cur_cmd_d;
        addr_o_d = AB_W'(cur_addr_d[OFFSET_W-1:0]);
        if (is_wr) data_o_d = cur_wdata_d[DATA_W-1:0];
      end
      S_DATA1: begin
        cmd_o_d  = cur_cmd_d;
        addr_o_d = AB_W'(cur_addr_d[OFFSET_W-1:0]);
        data_o_d = cur_wdata_d[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase

    rsp_valid_d = (state_d == S_DONE);
    rsp_err_d   = rsp_valid_d ? timeout : rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_d) rsp_rdata_d = timeout ? '0 : rbuf_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd_q[wr_ptr_q]   <= req_cmd;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cur_cmd_q   <= C_NOP;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      rbuf_q      <= '0;
      wcnt_q      <= '0;
      own_q       <= 1'b1;
      cmd_o_q     <= C_NOP;
      data_o_q    <= '0;
      addr_o_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cur_cmd_q   <= cur_cmd_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      rbuf_q      <= rbuf_d;
      wcnt_q      <= wcnt_d;
      own_q       <= own_d;
      cmd_o_q     <= cmd_o_d;
      data_o_q    <= data_o_d;
      addr_o_q    <= addr_o_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_bus   = own_q ? cmd_o_q : 'z;
  assign data_bus  = own_q ? data_o_q : 'z;
  assign addr_bus  = addr_o_q;
  assign bus_own   = own_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef C1M_LATENCY_STATS_EN
  logic [15:0] lat_q, lat_d;
  logic [15:0] rsp_lat_q, rsp_lat_d;
  logic [15:0] max_latency_q, max_latency_d;
  logic        cnt_now, cnt_nxt;

  // counted window: ADDR_HI up to and including the RESPONSE cycle
  assign cnt_now = (state_q inside {S_ADDR_HI, S_ADDR_LO, S_DATA1, S_WAIT});
  assign cnt_nxt = (state_d inside {S_ADDR_HI, S_ADDR_LO, S_DATA1, S_WAIT});

  always_comb begin
    lat_d         = lat_q;
    rsp_lat_d     = rsp_lat_q;
    max_latency_d = max_latency_q;
    if (state_q == S_IDLE && state_d == S_ADDR_HI) begin
      lat_d = 16'd1;
    end else if (cnt_now && cnt_nxt && lat_q != 16'hFFFF) begin
      lat_d = lat_q + 16'd1;
    end
    if (rsp_valid_d) begin
      rsp_lat_d = lat_q;
      if (!timeout && lat_q > max_latency_q) max_latency_d = lat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_q         <= '0;
      rsp_lat_q     <= '0;
      max_latency_q <= '0;
    end else begin
      lat_q         <= lat_d;
      rsp_lat_q     <= rsp_lat_d;
      max_latency_q <= max_latency_d;
    end
  end

  assign rsp_latency = rsp_lat_q;
`else
  assign rsp_latency = '0;
`endif

endmodule

// File: tb/tb_c1_bus_master.sv
// tb_c1_bus_master: random + directed bench for c1_bus_master with a
// transaction-level slave model and expected-result functions.
module tb_c1_bus_master;

  localparam int TO = 256;

  typedef struct {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
    int          k;
    bit          silent;
    logic [15:0] b0;
    logic [15:0] b1;
  } plan_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [18:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] rsp_latency;
  logic [14:0] addr_bus;
  wire  [2:0]  cmd_bus;
  wire  [15:0] data_bus;
  logic        bus_own;

  logic        s_drv = 1'b0;
  logic [2:0]  s_cmd = 3'd0;
  logic [15:0] s_data = '0;

  // slave only ever drives while the master has released the bus
  assign cmd_bus  = (s_drv && !bus_own) ? s_cmd : 'z;
  assign data_bus = (s_drv && !bus_own) ? s_data : 'z;

  always #5 clk = ~clk;

  c1_bus_master dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_latency (rsp_latency),
    .addr_bus    (addr_bus),
    .cmd_bus     (cmd_bus),
    .data_bus    (data_bus),
    .bus_own     (bus_own)
  );

  int    checks = 0;
  int    failures = 0;
  int    nrsp = 0;
  int    n_acc = 0;
  int    n_flush = 0;
  bit    busy = 1'b0;
  logic [31:0] m_max = '0;
  plan_t plan_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rdata(input plan_t p);
    if (p.silent) return 32'h0;
    case (p.cmd)
      3'd1:    return {24'h0, p.b0[7:0]};
      3'd2:    return {16'h0, p.b0};
      3'd3:    return {p.b1, p.b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_lat(input plan_t p);
`ifdef C1M_LATENCY_STATS_EN
    return 32'(p.k + 2 + ((p.cmd == 3'd7) ? 1 : 0));
`else
    return 32'(p.k * 0);
`endif
  endfunction

  function automatic bit m_is_wr(input logic [2:0] c);
    return c inside {3'd5, 3'd6, 3'd7};
  endfunction

  // called at the ADDR_HI negedge; follows one transaction to DONE
  task automatic serve(input plan_t p);
    int j;
    check("addr_hi_cmd", 32'(cmd_bus), 32'(p.cmd));
    check("addr_hi", 32'(addr_bus), 32'(p.addr[18:4]));
    @(negedge clk);
    if (!reset) return;
    check("addr_lo", 32'(addr_bus), 32'(p.addr[3:0]));
    if (m_is_wr(p.cmd))
      check("beat0", 32'(data_bus), 32'(p.wdata[15:0]));
    if (p.cmd == 3'd7) begin
      @(negedge clk);
      if (!reset) return;
      check("beat1", 32'(data_bus), 32'(p.wdata[31:16]));
    end
    @(negedge clk);
    if (!reset) return;
    check("turnaround", 32'(bus_own), 32'h0);
    j = 1;
    if (!p.silent) begin
      while (j < p.k) begin
        @(negedge clk);
        if (!reset) return;
        j++;
      end
      s_cmd  = 3'd7;
      s_data = p.b0;
      s_drv  = 1'b1;
      @(negedge clk);
      if (p.cmd == 3'd3) begin
        s_data = p.b1;
        check("rd32_early", 32'(rsp_valid), 32'h0);
        @(negedge clk);
      end
      s_drv = 1'b0;
    end else begin
      while (j < TO) begin
        @(negedge clk);
        if (!reset) return;
        j++;
      end
      @(negedge clk);
    end
    if (!reset) begin
      s_drv = 1'b0;
      return;
    end
    check("rsp_valid", 32'(rsp_valid), 32'h1);
    check("done_own", 32'(bus_own), 32'h1);
    check("done_cmd", 32'(cmd_bus), 32'h0);
    check("rdata", rsp_rdata, m_rdata(p));
    check("err", 32'(rsp_err), 32'(p.silent));
    if (!p.silent) begin
      check("latency", 32'(rsp_latency), m_lat(p));
`ifdef C1M_LATENCY_STATS_EN
      if (m_lat(p) > m_max) m_max = m_lat(p);
      check("max_lat", 32'(dut.max_latency_q), m_max);
`endif
    end
  endtask

  initial begin : slave
    forever begin
      @(negedge clk);
      if (reset && bus_own && cmd_bus != 3'd0) begin
        if (plan_q.size() == 0) begin
          check("spurious_issue", 32'(cmd_bus), 32'h0);
        end else begin
          busy = 1'b1;
          serve(plan_q.pop_front());
          s_drv = 1'b0;
          busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (rsp_valid === 1'b1) nrsp <= nrsp + 1;

  // called at a negedge; returns at the negedge after the accept edge
  task automatic push(input logic [2:0] c, input logic [18:0] a,
                      input logic [31:0] w, input int k, input bit sil,
                      input logic [15:0] b0, input logic [15:0] b1);
    int n;
    plan_t p;
    n = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_wdata = w;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("push_timeout", 32'h1, 32'h0);
    end else if (c != 3'd0) begin
      p.cmd = c; p.addr = a; p.wdata = w;
      p.k = k; p.silent = sil; p.b0 = b0; p.b1 = b1;
      plan_q.push_back(p);
      n_acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((plan_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain_timeout", 32'h1, 32'h0);
  endtask

  task automatic wait_released();
    int n;
    n = 0;
    while (bus_own && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("release_timeout", 32'h1, 32'h0);
  endtask

  function automatic logic [18:0] rnd_addr();
    return 19'($urandom_range(0, 19'h7FFFF));
  endfunction

  initial begin : wdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : main
    logic [2:0] c;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_own", 32'(bus_own), 32'h1);
    check("rst_cmd", 32'(cmd_bus), 32'h0);
    check("rst_data", 32'(data_bus), 32'h0);
    check("rst_addr", 32'(addr_bus), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_lat", 32'(rsp_latency), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    push(3'd7, 19'h7AA49, 32'h1234ABCD, 3, 1'b0, 16'h0, 16'h0);
    wait_done();
    push(3'd3, 19'h7AA49, 32'h0, 2, 1'b0, 16'hABCD, 16'h1234);
    wait_done();
    push(3'd1, rnd_addr(), 32'h0, 4, 1'b0, 16'hFF5A, 16'h0);
    wait_done();
    push(3'd1, rnd_addr(), 32'h0, 0, 1'b1, 16'h0, 16'h0);
    wait_done();

    push(3'd2, rnd_addr(), 32'h0, 30, 1'b0, 16'h5555, 16'h0);
    wait_released();
    for (int i = 0; i < 4; i++)
      push(3'($urandom_range(1, 7)), rnd_addr(), $urandom, 2 + i,
           1'b0, 16'($urandom), 16'($urandom));
    check("full_ready", 32'(req_ready), 32'h0);
    push(3'd3, rnd_addr(), 32'h0, 3, 1'b0, 16'h1111, 16'h2222);
    wait_done();

    for (int i = 0; i < 30; i++) begin
      c = 3'($urandom_range(0, 7));
      push(c, rnd_addr(), $urandom, int'($urandom_range(2, 10)),
           1'b0, 16'($urandom), 16'($urandom));
    end
    wait_done();

    push(3'd2, rnd_addr(), 32'h0, 0, 1'b1, 16'h0, 16'h0);
    wait_released();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_flush = 1;
    @(negedge clk);
    check("rst_wait_own", 32'(bus_own), 32'h1);
    check("rst_wait_cmd", 32'(cmd_bus), 32'h0);
    check("rst_wait_ready", 32'(req_ready), 32'h1);
    check("rst_wait_valid", 32'(rsp_valid), 32'h0);
    plan_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check("rsp_count", 32'(nrsp), 32'(n_acc - n_flush));
    check("idle_own", 32'(bus_own), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c1_bus_master.md
# c1_bus_master

Synthesizable CPU-side master for the C1 cache bus. It accepts queued requests on a valid/ready interface and drives the two-phase C1 address protocol with a shared tri-state command/data bus. It captures responses and reports data, completion status and per-request latency. The block replaces the behavioural read/write tasks in cache benches and sits between a traffic source (core model or stimulus engine) and `Cache`.

## Interface
- `TAG_W`, 10, tag bits.
- `SET_W`, 5, set-index bits.
- `OFFSET_W`, 4, line-offset bits; address = {tag, set, offset}, 19 bits by default.
- `DATA_W`, 16, C1 data bus width; 32-class ops use two beats.
- `QDEPTH`, 4, request FIFO depth, power of 2, ≥2.
- `TIMEOUT_CYC`, 256, maximum WAIT_RSP cycles before abort.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  FIFO not full.
- `req_cmd`  in  3  C1 command code.
- `req_addr`  in  TAG_W+SET_W+OFFSET_W  byte address.
- `req_wdata`  in  2*DATA_W  write data; beat0 = low half.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  2*DATA_W  read data; beat0 = low half; zero for writes and invalidates.
- `rsp_err`  out  1  request aborted by timeout.
- `rsp_latency`  out  16  request latency in cycles.
- `addr_bus`  out  max(TAG_W+SET_W, OFFSET_W)  C1 address.
- `cmd_bus`  inout  3  C1 command.
- `data_bus`  inout  DATA_W  C1 data.
- `bus_own`  out  1  master currently drives `cmd_bus`/`data_bus`.

## Operation
- Command codes: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7. RESPONSE is distinguished from WRITE32 by bus direction.
- Requests with `req_cmd` = NOP are accepted and dropped silently, with no response.
- FSM states and sequence: IDLE → ADDR_HI → ADDR_LO → [DATA1] → WAIT_RSP → [RD_BEAT1] → DONE → IDLE.
- IDLE: pops the FIFO head when it is non-empty.
- ADDR_HI: `cmd_bus`=cmd; `addr_bus`={tag,set}.
- ADDR_LO: `addr_bus`=offset, zero-extended; `data_bus`=beat0 for writes.
- DATA1: WRITE32 only; `data_bus`=beat1.
- WAIT_RSP: `bus_own`=0. The slave must not drive in the first WAIT_RSP cycle (turnaround). When `cmd_bus`==RESPONSE is sampled, beat0 is captured for reads.
- RD_BEAT1: READ32 only; captures beat1 in the cycle following RESPONSE.
- DONE: `bus_own`=1, `cmd_bus`=NOP, `rsp_valid`=1.
- Outside ADDR_HI through DATA1, the owned buses drive `cmd_bus`=NOP, `data_bus`=0, `addr_bus`=0.
- READ8/READ16 data is right-aligned in beat0. Upper bits of `rsp_rdata` are 0.
- Timeout: if RESPONSE is not seen within TIMEOUT_CYC WAIT_RSP cycles, go to DONE with `rsp_err`=1 and `rsp_rdata`=0.
- FIFO: `req_ready`=!full, taken from the registered count.
  - Push and pop in the same cycle are both performed.
  - When full, a push is refused even if a pop occurs that cycle.
  - Pointers wrap modulo QDEPTH.

## Timing
- Reset values:
  - `req_ready`=1 (FIFO empty).
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `rsp_latency`=0.
  - `addr_bus`=0, `cmd_bus`=NOP driven, `data_bus`=0 driven, `bus_own`=1.
  - FSM=IDLE.
- Reset asserted in any state returns to IDLE, empties the FIFO, reclaims the bus next edge and produces no response for the in-flight request.
- Issue latency: a request pushed at edge N with an empty FIFO and IDLE FSM is in ADDR_HI in cycle N+2.
- Latency count = cycles from ADDR_HI through the RESPONSE-sample cycle, inclusive.
  - Slave answering in the k-th WAIT_RSP cycle (k≥2) gives READ8/16/INVALIDATE = 2+k, WRITE8/16 = 2+k, WRITE32 = 3+k, READ32 = 2+k.
  - READ32 data is complete one cycle later.
  - The counter saturates at 0xFFFF.
- `rsp_valid` is asserted in DONE, one cycle after the last capture. Back-to-back requests are separated by the DONE and IDLE cycles.

## Configuration
- `C1M_LATENCY_STATS_EN` defined: `rsp_latency` carries the count above. An internal 16-bit `max_latency` register tracks the maximum over non-error responses; it is cleared by reset.
- Not defined: `rsp_latency` is tied to 0 and the counter and max register are not instantiated. Protocol behaviour is identical.

## Test plan
- Reset with `reset`=0 for 2 cycles → `bus_own`=1, `cmd_bus`=0, `req_ready`=1, `rsp_valid`=0.
- WRITE32 to 0x7AA49 with data 0x1234ABCD; slave answers at k=3 → beats seen: 0xABCD then 0x1234, offset 0x9 in ADDR_LO, `rsp_latency`=6, `rsp_err`=0.
- READ32 to 0x7AA49; slave returns 0xABCD, 0x1234 at k=2 → `rsp_rdata`=0x1234ABCD, `rsp_latency`=4.
- READ8 with slave returning 0xFF5A → `rsp_rdata`=0x0000005A. Slave silent for 256 cycles → `rsp_err`=1, `rsp_rdata`=0, bus reclaimed.
- Push 5 requests back-to-back with QDEPTH=4 while the slave stalls → `req_ready`=0 after the 4th accepted. The 5th is taken after the first pop; all 5 complete in order.
- Assert `reset` while in WAIT_RSP → no `rsp_valid`, `bus_own`=1 next cycle, FIFO empty.
